// File: rtl/md5_pkg.sv
// MD5 constants, per-step tables and the pipeline stage record shared by the
// md5_pipeline top and its md5_round steps.
package md5_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef struct packed {
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       c;
    logic [31:0]       d;
    logic [15:0][31:0] m;
  } md5_state_t;

  function automatic int unsigned msg_idx(input int unsigned r);
    case (r / 16)
      0:       return r;
      1:       return (5 * r + 1) % 16;
      2:       return (3 * r + 5) % 16;
      default: return (7 * r) % 16;
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/md5_round.sv
// One registered MD5 step; R selects function, constant, shift and message word.
module md5_round
  import md5_pkg::*;
#(
  parameter int unsigned R = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  md5_state_t i_state,
  output md5_state_t o_state
);

  localparam int unsigned G  = msg_idx(R);
  localparam logic [4:0]  SH = S[R];
  localparam logic [31:0] KR = K[R];

  logic [31:0] w_f;
  logic [31:0] w_t;
  md5_state_t  w_next;
  md5_state_t  r_state;

  always_comb begin
    w_f = '0;
    case (R / 16)
      0:       w_f = (i_state.b & i_state.c) | (~i_state.b & i_state.d);
      1:       w_f = (i_state.d & i_state.b) | (~i_state.d & i_state.c);
      2:       w_f = i_state.b ^ i_state.c ^ i_state.d;
      default: w_f = i_state.c ^ (i_state.b | ~i_state.d);
    endcase
  end

  always_comb begin
    w_t      = i_state.a + w_f + KR + i_state.m[4'(G)];
    w_next   = i_state;
    w_next.a = i_state.d;
    w_next.d = i_state.c;
    w_next.c = i_state.b;
    w_next.b = i_state.b + rotl(w_t, SH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= '0;
    else        r_state <= w_next;
  end

  assign o_state = r_state;

endmodule

// File: rtl/md5_pipeline.sv
// 64-step unrolled MD5 of a 0-15 byte candidate, one guess per clock, 65-edge latency.
// Optional MD5_VALID_EN adds an in_valid/out_valid sideband aligned with the hash.
module md5_pipeline
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] guess,
  input  logic [3:0]   guesslen,
  output logic [31:0]  hashA,
  output logic [31:0]  hashB,
  output logic [31:0]  hashC,
  output logic [31:0]  hashD
`ifdef MD5_VALID_EN
  ,
  input  logic         in_valid,
  output logic         out_valid
`endif
);

  logic [7:0]  w_byte [16];
  md5_state_t  w_blk;
  md5_state_t  r_in;
  md5_state_t  w_st [65];
  logic [31:0] r_ha, r_hb, r_hc, r_hd;
  logic        w_unused_m;

  // Only the first 16 bytes can hold data or the 0x80 marker (guesslen <= 15).
  always_comb begin
    w_byte = '{default: '0};
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < 32'(guesslen))       w_byte[i] = guess[127 - 8*i -: 8];
      else if (i == 32'(guesslen)) w_byte[i] = 8'h80;
      else                         w_byte[i] = 8'h00;
    end
  end

  always_comb begin
    w_blk   = '0;
    w_blk.a = IV_A;
    w_blk.b = IV_B;
    w_blk.c = IV_C;
    w_blk.d = IV_D;
    for (int unsigned j = 0; j < 4; j++)
      w_blk.m[j] = {w_byte[4*j+3], w_byte[4*j+2], w_byte[4*j+1], w_byte[4*j]};
    w_blk.m[14] = {25'b0, guesslen, 3'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in <= '0;
    else        r_in <= w_blk;
  end

  assign w_st[0] = r_in;

  for (genvar gr = 0; gr < 64; gr++) begin : g_round
    md5_round #(.R(gr)) u_round (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_state (w_st[gr]),
      .o_state (w_st[gr+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ha <= '0;
      r_hb <= '0;
      r_hc <= '0;
      r_hd <= '0;
    end else begin
      r_ha <= IV_A + w_st[64].a;
      r_hb <= IV_B + w_st[64].b;
      r_hc <= IV_C + w_st[64].c;
      r_hd <= IV_D + w_st[64].d;
    end
  end

  assign hashA = r_ha;
  assign hashB = r_hb;
  assign hashC = r_hc;
  assign hashD = r_hd;

  assign w_unused_m = ^w_st[64].m;

`ifdef MD5_VALID_EN
  logic [64:0] r_vsr;
  logic        r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsr       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_vsr       <= {r_vsr[63:0], in_valid};
      r_out_valid <= r_vsr[64];
    end
  end

  assign out_valid = r_out_valid;
`endif

endmodule

// File: tb/tb_md5_pipeline.sv
// Bench for md5_pipeline: known-answer vectors plus random candidates against a
// byte-level MD5 reference model; honours MD5_VALID_EN when defined.
module tb_md5_pipeline;

  localparam int unsigned DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] guess;
  logic [3:0]   guesslen;
  logic [31:0]  hashA, hashB, hashC, hashD;
`ifdef MD5_VALID_EN
  logic         in_valid;
  logic         out_valid;
`endif

  int unsigned  nvec = 0;
  int unsigned  nerr = 0;
  int unsigned  cyc  = 0;
  logic [127:0] exp_h  [DEPTH];
  bit           exp_v  [DEPTH];
  logic [127:0] stale_h[DEPTH];
  bit           stale_v[DEPTH];

  md5_pipeline u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .guess    (guess),
    .guesslen (guesslen),
    .hashA    (hashA),
    .hashB    (hashB),
    .hashC    (hashC),
    .hashD    (hashD)
`ifdef MD5_VALID_EN
    ,
    .in_valid (in_valid),
    .out_valid(out_valid)
`endif
  );

  always #5 clk = ~clk;

  // Straight from the MD5 definition: padded bytes, sine-derived constants.
  function automatic logic [127:0] md5_ref(input logic [127:0] g, input int unsigned len);
    logic [7:0]  blk [64];
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t, k;
    int unsigned gi, s;
    int unsigned sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                               '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    real x;
    for (int unsigned i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < len)       blk[i] = g[127 - 8*i -: 8];
      else if (i == len) blk[i] = 8'h80;
    end
    for (int unsigned j = 0; j < 16; j++)
      m[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    m[14] = len * 8;
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int unsigned r = 0; r < 64; r++) begin
      case (r / 16)
        0:       begin f = (b & c) | (~b & d); gi = r;               end
        1:       begin f = (b & d) | (c & ~d); gi = (5*r + 1) % 16;  end
        2:       begin f = b ^ c ^ d;          gi = (3*r + 5) % 16;  end
        default: begin f = c ^ (b | ~d);       gi = (7*r) % 16;      end
      endcase
      x = $sin(real'(r + 1));
      if (x < 0.0) x = -x;
      k = 32'(longint'($floor(x * 4294967296.0)));
      s = sh[r/16][r%4];
      t = a + f + k + m[gi];
      a = d; d = c; c = b;
      b = b + ((t << s) | (t >> (32 - s)));
    end
    return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n === 1'b0) begin
      chk32("rstA", hashA, '0); chk32("rstB", hashB, '0);
      chk32("rstC", hashC, '0); chk32("rstD", hashD, '0);
    end else if (cyc < DEPTH) begin
      if (exp_v[cyc]) begin
        chk32("hashA", hashA, exp_h[cyc][127:96]);
        chk32("hashB", hashB, exp_h[cyc][95:64]);
        chk32("hashC", hashC, exp_h[cyc][63:32]);
        chk32("hashD", hashD, exp_h[cyc][31:0]);
      end
      if (stale_v[cyc]) begin
        nvec++;
        assert ({hashA, hashB, hashC, hashD} !== stale_h[cyc]) else begin
          nerr++;
          $error("FAIL stale cyc=%0d observed=%h expected!=%h", cyc,
                 {hashA, hashB, hashC, hashD}, stale_h[cyc]);
        end
      end
`ifdef MD5_VALID_EN
      nnvalid_chk();
`endif
    end
  endtask

`ifdef MD5_VALID_EN
  task automatic nnvalid_chk();
    nvec++;
    assert (out_valid === exp_v[cyc]) else begin
      nerr++;
      $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, out_valid, exp_v[cyc]);
    end
  endtask
`endif

  // Result of the input held now is sampled at edge cyc+1 and emerges 65 edges later.
  task automatic apply(input logic [127:0] g, input logic [3:0] len, input logic [127:0] expv);
    guess = g;
    guesslen = len;
`ifdef MD5_VALID_EN
    in_valid = 1'b1;
`endif
    if (cyc + 66 < DEPTH) begin
      exp_h[cyc + 66] = expv;
      exp_v[cyc + 66] = 1'b1;
    end
    tick();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      guess = {$urandom, $urandom, $urandom, $urandom};
      guesslen = 4'($urandom_range(0, 15));
`ifdef MD5_VALID_EN
      in_valid = 1'b0;
`endif
      tick();
    end
  endtask

  task automatic apply_rand();
    logic [127:0] g;
    logic [3:0]   l;
    g = {$urandom, $urandom, $urandom, $urandom};
    l = 4'($urandom_range(0, 15));
    apply(g, l, md5_ref(g, 32'(l)));
  endtask

  initial begin
    logic [127:0] g;
    for (int i = 0; i < int'(DEPTH); i++) begin
      exp_v[i] = 1'b0;
      stale_v[i] = 1'b0;
    end
    rst_n = 1'b0;
    guess = '0;
    guesslen = '0;
`ifdef MD5_VALID_EN
    in_valid = 1'b0;
`endif
    #1;
    chk32("rst0A", hashA, '0);
    chk32("rst0D", hashD, '0);
    tick(); tick();
    rst_n = 1'b1;
    idle(70);

    // Known answers, back to back: "", "a", "abc", then "abc" with garbage tail.
    apply({$urandom, $urandom, $urandom, $urandom}, 4'd0,
          128'hd98c1dd4_04b2008f_980980e9_7e42f8ec);
    apply({8'h61, 120'h0}, 4'd1, 128'hb975c10c_a8b6f1c0_e299c331_61267769);
    apply({32'h61626364, 96'h0}, 4'd3, 128'h98500190_b04fd23c_7d3f96d6_727fe128);
    g = {$urandom, $urandom, $urandom, $urandom};
    g[127:104] = 24'h616263;
    apply(g, 4'd3, 128'h98500190_b04fd23c_7d3f96d6_727fe128);
    g = {$urandom, $urandom, $urandom, $urandom};
    apply(g, 4'd15, md5_ref(g, 15));
    idle(3);

    for (int i = 0; i < 40; i++) apply_rand();
    idle(70);

    // Abort in-flight guesses: nothing they would have produced may appear.
    for (int i = 0; i < 10; i++) apply_rand();
    rst_n = 1'b0;
    #1;
    chk32("rstMidA", hashA, '0);
    chk32("rstMidB", hashB, '0);
    chk32("rstMidC", hashC, '0);
    chk32("rstMidD", hashD, '0);
    for (int unsigned c = cyc + 1; c < DEPTH; c++) begin
      if (exp_v[c]) begin
        stale_h[c] = exp_h[c];
        stale_v[c] = 1'b1;
        exp_v[c] = 1'b0;
      end
    end
    tick(); tick(); tick();
    rst_n = 1'b1;
    idle(70);

    for (int i = 0; i < 8; i++) apply_rand();
    apply({32'h61626364, 96'h0}, 4'd3, 128'h98500190_b04fd23c_7d3f96d6_727fe128);
    idle(70);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
